ahblite_sram_slave: RTL and testbench

AHBLITE_SRAM_SLAVE -- requirements
Module: ahblite_sram_slave

---
 rtl/ahblite_pkg.sv | 50 +++++
 rtl/ahblite_sram_mem.sv | 23 ++
 rtl/ahblite_sram_slave.sv | 111 +++++++++++
 tb/tb_ahblite_sram_slave.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings, SRAM slave state type and byte-lane helpers.
package ahblite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;
    localparam logic [2:0] HSIZE_B64  = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } sram_state_t;

    // Little-endian byte-lane strobe for a 32-bit data bus.
    function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] strb;
        strb = 4'b0000;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr;
            HSIZE_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strb = 4'b1111;
            default:    strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // Oversized or misaligned transfers get an ERROR response.
    function automatic logic xfer_illegal(input logic [2:0] size, input logic [1:0] addr);
        logic bad;
        bad = 1'b0;
        if (size > HSIZE_WORD)
            bad = 1'b1;
        else if (size == HSIZE_HALF && addr[0])
            bad = 1'b1;
        else if (size == HSIZE_WORD && addr != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/ahblite_sram_mem.sv
// Word-organised SRAM with per-byte write enables and combinational read.
module ahblite_sram_mem #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-3:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 1 << (ADDR_W - 2);

    logic [31:0] mem [DEPTH];

    // Byte-masked write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahblite_sram_slave.sv
// AHB-Lite SRAM slave: pipelined address/data phases, fixed wait states,
// two-cycle ERROR response for oversized or misaligned transfers.
module ahblite_sram_slave
    import ahblite_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);
    localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    sram_state_t       state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic              dp_valid, dp_write;
    logic [ADDR_W-1:0] dp_addr;
    logic [2:0]        dp_size;
    logic              ready, accept, req_err, dp_done;
    logic [3:0]        mem_we;
    logic [31:0]       mem_rdata;
    logic              unused_bits;

    assign unused_bits = ^{HBURST, HPROT, HADDR[31:ADDR_W], HTRANS[0]};

    // Slave is ready only in ST_IDLE and ST_ERR2; a new address phase is
    // sampled only then, so nothing is taken while HREADYOUT is low.
    assign ready   = (state == ST_IDLE) || (state == ST_ERR2);
    assign accept  = HSEL && HTRANS[1] && HREADY && ready;
    assign req_err = xfer_illegal(HSIZE, HADDR[1:0]);
    assign dp_done = dp_valid && (state == ST_IDLE);

    assign HREADYOUT = ready;
    assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (dp_done && !dp_write) ? mem_rdata : 32'h0;
    assign mem_we    = (dp_done && dp_write) ? byte_strobe(dp_size, dp_addr[1:0]) : 4'b0000;

    // State and wait-counter register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: wait countdown, error sequencing, new-transfer launch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_WAIT: begin
                if (cnt == 2'd0) state_nxt = ST_IDLE;
                else             cnt_nxt   = cnt - 2'd1;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (accept) begin
            if (req_err) begin
                state_nxt = ST_ERR1;
            end else if (WAIT_STATES == 0) begin
                state_nxt = ST_IDLE;
            end else begin
                state_nxt = ST_WAIT;
                cnt_nxt   = WAIT_LOAD;
            end
        end
    end

    // Address-phase register; reloaded whenever the slave is ready.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_size  <= HSIZE_BYTE;
        end else if (ready) begin
            dp_valid <= accept && !req_err;
            if (accept) begin
                dp_write <= HWRITE;
                dp_addr  <= HADDR[ADDR_W-1:0];
                dp_size  <= HSIZE;
            end
        end
    end

    ahblite_sram_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (HCLK),
        .we    (mem_we),
        .addr  (dp_addr[ADDR_W-1:2]),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ahblite_sram_slave.sv
// Bench for ahblite_sram_slave: two instances (0 and 2 wait states) driven by
// a pipelined bus master, checked every cycle against a transfer-level model.
module tb_ahblite_sram_slave;
    import ahblite_pkg::*;

    localparam int ADDR_W = 12;
    localparam int NI     = 2;
    localparam int MEMB   = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        hsel[NI], hwrite[NI], hreadyout[NI], hresp[NI];
    logic [31:0] haddr[NI], hwdata[NI], hrdata[NI];
    logic [1:0]  htrans[NI];
    logic [2:0]  hsize[NI], hburst[NI];
    logic [3:0]  hprot[NI];

    int n_chk = 0;
    int n_fail = 0;

    ahblite_sram_slave #(.ADDR_W(ADDR_W), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HPROT(hprot[0]),
        .HWDATA(hwdata[0]), .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]),
        .HRDATA(hrdata[0]), .HRESP(hresp[0]));

    ahblite_sram_slave #(.ADDR_W(ADDR_W), .WAIT_STATES(2)) dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HPROT(hprot[1]),
        .HWDATA(hwdata[1]), .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]),
        .HRDATA(hrdata[1]), .HRESP(hresp[1]));

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, i, act, exp, $time);
        end
    endtask

    // ---------------- transfer-level model ----------------
    typedef enum int {K_NONE, K_OK, K_ERR} kind_e;
    kind_e       m_kind[NI];
    int          m_wait[NI];
    bit          m_err2[NI];
    bit          m_wr[NI];
    int          m_addr[NI];
    int          m_size[NI];
    logic [7:0]  m_mem[NI][MEMB];
    bit          m_known[NI][MEMB];

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic bit illegal(input logic [2:0] sz, input logic [1:0] a);
        if (int'(sz) > 2) return 1'b1;
        return (int'(a) % (1 << int'(sz))) != 0;
    endfunction

    function automatic bit exp_ready(input int i);
        if (m_kind[i] == K_OK)  return m_wait[i] == 0;
        if (m_kind[i] == K_ERR) return m_err2[i];
        return 1'b1;
    endfunction

    // {known, data}: full addressed word in the last cycle of a read, else 0.
    function automatic logic [32:0] exp_rd(input int i);
        logic [31:0] w;
        bit known;
        int base;
        w = 32'h0;
        known = 1'b1;
        if (!(m_kind[i] == K_OK && m_wait[i] == 0 && !m_wr[i])) return {1'b1, 32'h0};
        base = m_addr[i] & ~3;
        for (int k = 0; k < 4; k++) begin
            w[8*k +: 8] = m_mem[i][base + k];
            if (!m_known[i][base + k]) known = 1'b0;
        end
        return {known, w};
    endfunction

    // Advance the model at each edge; the write lands when its data phase ends.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_kind[i] <= K_NONE;
            end else begin
                if (m_kind[i] == K_OK && m_wait[i] > 0) m_wait[i] <= m_wait[i] - 1;
                if (m_kind[i] == K_ERR && !m_err2[i]) m_err2[i] <= 1'b1;
                if (exp_ready(i)) begin
                    if (m_kind[i] == K_OK && m_wr[i])
                        for (int k = 0; k < (1 << m_size[i]); k++) begin
                            m_mem[i][m_addr[i] + k]   <= hwdata[i][8*((m_addr[i] + k) % 4) +: 8];
                            m_known[i][m_addr[i] + k] <= 1'b1;
                        end
                    if (hsel[i] && htrans[i][1]) begin
                        if (illegal(hsize[i], haddr[i][1:0])) begin
                            m_kind[i] <= K_ERR;
                            m_err2[i] <= 1'b0;
                        end else begin
                            m_kind[i] <= K_OK;
                            m_wait[i] <= ws_of(i);
                            m_wr[i]   <= hwrite[i];
                            m_addr[i] <= int'(haddr[i][ADDR_W-1:0]);
                            m_size[i] <= int'(hsize[i]);
                        end
                    end else begin
                        m_kind[i] <= K_NONE;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic [32:0] er;
            er = exp_rd(i);
            chk("hreadyout", i, {31'h0, hreadyout[i]}, {31'h0, exp_ready(i)});
            chk("hresp", i, {31'h0, hresp[i]}, {31'h0, (m_kind[i] == K_ERR) ? HRESP_ERROR : HRESP_OKAY});
            if (er[32]) chk("hrdata", i, hrdata[i], er[31:0]);
        end
    end

    // ---------------- bus master ----------------
    // Drive one address phase, wait until it is taken; returns what the
    // previous data phase produced in its final cycle and how many wait cycles.
    task automatic beat(input int i, input bit sel, input logic [1:0] tr, input logic wr,
                        input logic [31:0] addr, input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] prd, output logic prsp, output int waits);
        logic rdy;
        rdy = 1'b0;
        hsel[i] = sel; htrans[i] = tr; hwrite[i] = wr; haddr[i] = addr; hsize[i] = sz;
        waits = 0;
        prd = 32'h0;
        prsp = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rdy = hreadyout[i]; prd = hrdata[i]; prsp = hresp[i];
            @(posedge clk); #1;
            if (rdy) break;
            waits++;
        end
        if (!rdy) begin
            n_chk++; n_fail++;
            $display("FAIL timeout inst%0d: HREADYOUT never high", i);
        end
        hwdata[i] = wd;
    endtask

    logic [31:0] rd;
    logic        rs;
    int          w;
    logic [1:0]  btr[6];
    logic [31:0] bad[6];
    logic [31:0] bex[5];

    initial begin
        for (int i = 0; i < NI; i++) begin
            hsel[i] = 0; htrans[i] = HTRANS_IDLE; hwrite[i] = 0; haddr[i] = 0;
            hsize[i] = HSIZE_WORD; hburst[i] = 3'b000; hprot[i] = 4'b0011; hwdata[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset hreadyout", i, {31'h0, hreadyout[i]}, 32'h1);
            chk("reset hresp", i, {31'h0, hresp[i]}, 32'h0);
            chk("reset hrdata", i, hrdata[i], 32'h0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // zero wait states: write then read back-to-back
        beat(0, 1, HTRANS_NONSEQ, 1, 32'h010, HSIZE_WORD, 32'hDEADBEEF, rd, rs, w);
        beat(0, 1, HTRANS_NONSEQ, 0, 32'h010, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("ws0 write waits", 0, 32'(w), 32'd0);
        chk("ws0 write resp", 0, {31'h0, rs}, 32'h0);
        beat(0, 1, HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("ws0 read waits", 0, 32'(w), 32'd0);
        chk("ws0 read data", 0, rd, 32'hDEADBEEF);

        // unselected transfer must be ignored
        beat(0, 0, HTRANS_NONSEQ, 1, 32'h010, HSIZE_WORD, 32'h12345678, rd, rs, w);
        beat(0, 1, HTRANS_NONSEQ, 0, 32'h010, HSIZE_WORD, 32'h0, rd, rs, w);
        beat(0, 1, HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("hsel0 ignored", 0, rd, 32'hDEADBEEF);

        // INCR4 burst with a BUSY after beat 2, written then read back
        btr = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_BUSY, HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE};
        bad = '{32'h040, 32'h044, 32'h048, 32'h048, 32'h04C, 32'h0};
        bex = '{32'h10000000, 32'h10000001, 32'h0, 32'h10000002, 32'h10000003};
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 6; k++) begin
                hburst[0] = 3'b011;
                beat(0, 1, btr[k], (p == 0), bad[k], HSIZE_WORD,
                     32'h10000000 + 32'(k) - ((k > 2) ? 32'd1 : 32'd0), rd, rs, w);
                if (k > 0) begin
                    chk("burst waits", 0, 32'(w), 32'd0);
                    chk("burst resp", 0, {31'h0, rs}, 32'h0);
                    if (p == 1) chk("burst rdata", 0, rd, bex[k-1]);
                end
            end
        end
        hburst[0] = 3'b000;

        // two wait states: byte merge into an existing word
        beat(1, 1, HTRANS_NONSEQ, 1, 32'h010, HSIZE_WORD, 32'h11223344, rd, rs, w);
        beat(1, 1, HTRANS_NONSEQ, 1, 32'h013, HSIZE_BYTE, 32'hAA000000, rd, rs, w);
        chk("ws2 write waits", 1, 32'(w), 32'd2);
        beat(1, 1, HTRANS_NONSEQ, 0, 32'h010, HSIZE_WORD, 32'h0, rd, rs, w);
        beat(1, 1, HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("byte merge", 1, rd, 32'hAA223344);

        // single read with two wait states, then halfword merge
        beat(1, 1, HTRANS_NONSEQ, 1, 32'h020, HSIZE_WORD, 32'h5A5A1234, rd, rs, w);
        beat(1, 1, HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, rd, rs, w);
        beat(1, 1, HTRANS_NONSEQ, 0, 32'h020, HSIZE_WORD, 32'h0, rd, rs, w);
        beat(1, 1, HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("ws2 read waits", 1, 32'(w), 32'd2);
        chk("ws2 read data", 1, rd, 32'h5A5A1234);
        beat(1, 1, HTRANS_NONSEQ, 1, 32'h022, HSIZE_HALF, 32'hBEEF0000, rd, rs, w);
        beat(1, 1, HTRANS_NONSEQ, 0, 32'h022, HSIZE_HALF, 32'h0, rd, rs, w);
        beat(1, 1, HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("half merge", 1, rd, 32'hBEEF1234);

        // error responses: misaligned word, 64-bit size, misaligned half
        beat(1, 1, HTRANS_NONSEQ, 0, 32'h006, HSIZE_WORD, 32'h0, rd, rs, w);
        beat(1, 1, HTRANS_NONSEQ, 1, 32'h010, HSIZE_B64, 32'hFFFFFFFF, rd, rs, w);
        chk("misalign waits", 1, 32'(w), 32'd1);
        chk("misalign resp", 1, {31'h0, rs}, 32'h1);
        beat(1, 1, HTRANS_NONSEQ, 1, 32'h011, HSIZE_HALF, 32'hFFFFFFFF, rd, rs, w);
        chk("b64 waits", 1, 32'(w), 32'd1);
        chk("b64 resp", 1, {31'h0, rs}, 32'h1);
        beat(1, 1, HTRANS_NONSEQ, 0, 32'h010, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("half err resp", 1, {31'h0, rs}, 32'h1);
        beat(1, 1, HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("mem after err", 1, rd, 32'hAA223344);

        // reset during the wait states of a write
        beat(1, 1, HTRANS_NONSEQ, 1, 32'h020, HSIZE_WORD, 32'hCAFEF00D, rd, rs, w);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("midreset hreadyout", 1, {31'h0, hreadyout[1]}, 32'h1);
        chk("midreset hresp", 1, {31'h0, hresp[1]}, 32'h0);
        chk("midreset hrdata", 1, hrdata[1], 32'h0);
        hsel[1] = 0; htrans[1] = HTRANS_IDLE;
        @(posedge clk); #1 rst = 1'b0;
        beat(1, 1, HTRANS_NONSEQ, 0, 32'h020, HSIZE_WORD, 32'h0, rd, rs, w);
        beat(1, 1, HTRANS_IDLE, 0, 32'h0, HSIZE_WORD, 32'h0, rd, rs, w);
        chk("write dropped", 1, rd, 32'hBEEF1234);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
